// File: rtl/franken_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package franken_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] STATUS_OFF = 32'd4;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

  // The STATUS count field is 8 bits wide; deeper FIFOs report 255 when fuller.
  function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
    logic [7:0] res;
    if (cnt > 32'd255) begin
      res = 8'hFF;
    end else begin
      res = cnt[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; a push into a full FIFO is
// taken only when a pop happens on the same edge, and pop-when-empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Storage array write port; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA queue bytes,
// STATUS reports FIFO occupancy, busy and a sticky overflow flag.
module mmio_uart_tx
  import franken_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFF;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFF;
  localparam logic [15:0] BAUD_MAX    = 16'(CLKS_PER_BIT - 1);

  uart_state_e state_r;
  logic [15:0] baud_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  data_r;
  logic        tx_r;
  logic        ovf_r;

  logic          push_s, pop_s, ovf_set_s, ovf_clr_s, baud_last_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_rd_data_s;
  logic [CW-1:0] fifo_count_s;
  logic          unused_bits_s;

  assign unused_bits_s = ^{byte_enable[3:1], write_data[31:8]};

  assign push_s      = mem_write && byte_enable[0] && (addr == TXDATA_ADDR);
  assign ovf_clr_s   = mem_write && byte_enable[0] && (addr == STATUS_ADDR) && write_data[3];
  assign baud_last_s = (baud_r == BAUD_MAX);
  // The next byte leaves the queue either from idle or on the last stop cycle.
  assign pop_s       = !fifo_empty_s &&
                       ((state_r == IDLE) || ((state_r == STOP) && baud_last_s));
  assign ovf_set_s   = push_s && fifo_full_s && !pop_s;
  assign tx          = tx_r;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (write_data[7:0]),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr_s) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Serialiser FSM with registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      data_r    <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          baud_r    <= 16'd0;
          bit_idx_r <= 3'd0;
          if (!fifo_empty_s) begin
            data_r  <= fifo_rd_data_s;
            tx_r    <= 1'b0;
            state_r <= START;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        START: begin
          if (baud_last_s) begin
            baud_r  <= 16'd0;
            tx_r    <= data_r[0];
            state_r <= DATA;
          end else begin
            baud_r  <= baud_r + 16'd1;
          end
        end
        DATA: begin
          if (baud_last_s) begin
            baud_r    <= 16'd0;
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              tx_r    <= data_r[bit_idx_r + 3'd1];
            end
          end else begin
            baud_r <= baud_r + 16'd1;
          end
        end
        STOP: begin
          if (baud_last_s) begin
            baud_r <= 16'd0;
            if (!fifo_empty_s) begin
              data_r  <= fifo_rd_data_s;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= IDLE;
            end
          end else begin
            baud_r <= baud_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          baud_r  <= 16'd0;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // STATUS readback decode; every other address reads as zero.
  always_comb begin
    read_data = 32'h0000_0000;
    if (addr == STATUS_ADDR) begin
      read_data[15:8]           = sat_count8(32'(fifo_count_s));
      read_data[STAT_OVF_BIT]   = ovf_r;
      read_data[STAT_BUSY_BIT]  = (state_r != IDLE);
      read_data[STAT_EMPTY_BIT] = fifo_empty_s;
      read_data[STAT_FULL_BIT]  = fifo_full_s;
    end else begin
      read_data = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx against a queue-based model of the
// byte FIFO and the expected serial line waveform.
module tb_mmio_uart_tx;

  localparam int          CPB     = 4;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] TX_ADDR = 32'h0000_1000;
  localparam logic [31:0] ST_ADDR = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [3:0]  byte_enable = 4'h0;
  logic [31:0] write_data = 32'h0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] fifo_q[$];
  bit         line_q[$];
  bit         ovf_m = 1'b0;
  bit         busy_m = 1'b0;
  bit         tx_m = 1'b1;

  mmio_uart_tx #(.BASE_ADDR(TX_ADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .byte_enable (byte_enable),
    .write_data  (write_data),
    .mem_write   (mem_write),
    .read_data   (read_data),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(fifo_q.size());
    return {16'h0, cnt, 4'h0, ovf_m, busy_m, fifo_q.size() == 0, fifo_q.size() == DEPTH};
  endfunction

  // One rising edge of the model: a byte leaves the queue when the line has
  // nothing left to send, and becomes 10 bit-times of samples.
  task automatic model_edge();
    bit pop, push, clr, acc;
    logic [7:0] b;
    if (reset) begin
      fifo_q.delete();
      line_q.delete();
      ovf_m = 1'b0; busy_m = 1'b0; tx_m = 1'b1;
      return;
    end
    pop  = (fifo_q.size() != 0) && (line_q.size() == 0);
    push = mem_write && byte_enable[0] && (addr == TX_ADDR);
    clr  = mem_write && byte_enable[0] && (addr == ST_ADDR) && write_data[3];
    acc  = push && ((fifo_q.size() < DEPTH) || pop);
    if (pop) begin
      b = fifo_q.pop_front();
      for (int k = 0; k < CPB; k++) line_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < CPB; k++) line_q.push_back(b[i]);
      for (int k = 0; k < CPB; k++) line_q.push_back(1'b1);
    end
    if (acc) fifo_q.push_back(write_data[7:0]);
    if (push && !acc) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (line_q.size() > 0) begin
      tx_m = line_q.pop_front(); busy_m = 1'b1;
    end else begin
      tx_m = 1'b1; busy_m = 1'b0;
    end
  endtask

  task automatic step(input logic w, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic rst);
    mem_write = w; addr = a; byte_enable = be; write_data = d; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    check_val("tx", 32'(tx), 32'(tx_m));
    check_val("read_data", read_data, (a == ST_ADDR) ? model_status() : 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ST_ADDR, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [9:0] frame_bits;
    bit found;

    // Reset state
    step(1'b0, ST_ADDR, 4'h0, 32'h0, 1'b1);
    step(1'b1, TX_ADDR, 4'h1, 32'h0000_00AA, 1'b1);
    idle(1);
    check_val("reset_tx", 32'(tx), 32'h1);
    check_val("reset_status", read_data, 32'h0000_0002);

    // Single frame of 0x55, sampled mid-bit
    step(1'b1, TX_ADDR, 4'h1, 32'hFFFF_FF55, 1'b0);
    for (int c = 0; c < 10 * CPB; c++) begin
      idle(1);
      if ((c % CPB) == CPB / 2) frame_bits[c / CPB] = tx;
    end
    check_val("frame55", 32'(frame_bits), 32'(10'b1_0101_0101_0));
    idle(1);
    check_val("frame55_done", read_data, 32'h0000_0002);

    // Byte lane 0 not enabled: no push
    step(1'b1, TX_ADDR, 4'b0010, 32'h0000_0041, 1'b0);
    idle(1);
    check_val("be0010_nopush", read_data, 32'h0000_0002);

    // Six back-to-back pushes: overflow, then clear it
    for (int i = 0; i < 6; i++) step(1'b1, TX_ADDR, 4'h1, 32'(8'h30 + i), 1'b0);
    idle(1);
    check_val("six_push_status", read_data, 32'h0000_040D);
    step(1'b1, ST_ADDR, 4'h1, 32'h0000_0008, 1'b0);
    check_val("ovf_clear", read_data, 32'h0000_0405);
    idle(5 * 10 * CPB + 5);
    check_val("drain_status", read_data, 32'h0000_0002);

    // Full FIFO plus push on the stop-end pop edge
    step(1'b0, ST_ADDR, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, TX_ADDR, 4'h1, 32'(8'hC0 + i), 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (line_q.size() == 0 && busy_m && fifo_q.size() == DEPTH) found = 1'b1;
      else idle(1);
    end
    check_val("stop_pop_reached", 32'(found), 32'h1);
    step(1'b1, TX_ADDR, 4'h1, 32'h0000_00E7, 1'b0);
    idle(1);
    check_val("push_on_pop", read_data, 32'h0000_0405);
    idle(6 * 10 * CPB);

    // Reset in the middle of data bit 3
    step(1'b1, TX_ADDR, 4'h1, 32'h0000_00F0, 1'b0);
    idle(17);
    step(1'b0, ST_ADDR, 4'h0, 32'h0, 1'b1);
    check_val("midframe_reset_tx", 32'(tx), 32'h1);
    check_val("midframe_reset_status", read_data, 32'h0000_0002);
    idle(12 * CPB);
    check_val("no_frame_after_reset", read_data, 32'h0000_0002);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1, 2, 3: a = TX_ADDR;
        4, 5:       a = ST_ADDR;
        6:          a = TX_ADDR + 32'd8;
        default:    a = $urandom;
      endcase
      step(($urandom % 4) == 0, a, 4'($urandom), $urandom, ($urandom % 600) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
